// File: rtl/control_suma_serial_pkg.sv
// Shared types for the serial wide-adder controller.
package pkg_suma_serial;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } estado_t;

endpackage

// File: rtl/control_suma_serial_suma.sv
// W-bit ripple adder with carry in/out; the single shared datapath of the controller.
module suma #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/control_suma_serial.sv
// Multi-cycle W*K-bit adder: one W-bit chunk per cycle through a shared adder,
// LSB chunk first, with the carry held in a register between chunks.
module control_suma_serial
  import pkg_suma_serial::*;
#(
  parameter int W = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W*K-1:0] a,
  input  logic [W*K-1:0] b,
  input  logic           cin,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [W*K-1:0] s,
  output logic           cout
);

  localparam int            IW       = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

  estado_t        estado_r;
  estado_t        estado_s;
  logic [IW-1:0]  idx_r;
  logic           carry_r;
  logic [W*K-1:0] a_r;
  logic [W*K-1:0] b_r;
  logic [W*K-1:0] wrk_r;
  logic [W*K-1:0] wrk_s;
  logic [W*K-1:0] s_r;
  logic           cout_r;
  logic [W-1:0]   op_a_s;
  logic [W-1:0]   op_b_s;
  logic [W-1:0]   sum_s;
  logic           chunk_cout_s;

  // Chunk selection and the work word with the current chunk merged in
  always_comb begin
    op_a_s = a_r[idx_r*W +: W];
    op_b_s = b_r[idx_r*W +: W];
    wrk_s  = wrk_r;
    wrk_s[idx_r*W +: W] = sum_s;
  end

  suma #(.N(W)) u_suma (
    .a    (op_a_s),
    .b    (op_b_s),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (chunk_cout_s)
  );

  // Next-state logic
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      IDLE: begin
        if (start) estado_s = SUMA;
        else       estado_s = IDLE;
      end
      SUMA: begin
        if (idx_r == IDX_LAST) estado_s = FIN;
        else                   estado_s = SUMA;
      end
      FIN:     estado_s = IDLE;
      default: estado_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) estado_r <= IDLE;
    else        estado_r <= estado_s;
  end

  // Operand capture, chunk iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      wrk_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      s_r     <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (estado_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= '0;
          end
        end
        SUMA: begin
          wrk_r   <= wrk_s;
          carry_r <= chunk_cout_s;
          if (idx_r == IDX_LAST) begin
            idx_r  <= '0;
            s_r    <= wrk_s;
            cout_r <= chunk_cout_s;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status is a pure decode of the state register
  assign ready = (estado_r == IDLE);
  assign busy  = (estado_r == SUMA) || (estado_r == FIN);
  assign done  = (estado_r == FIN);
  assign s     = s_r;
  assign cout  = cout_r;

endmodule

// File: tb/tb_control_suma_serial.sv
// Directed self-checking bench for control_suma_serial (W=4,K=4 and W=8,K=1).
module tb_control_suma_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;

  logic        start1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        cin1;
  logic        ready1;
  logic        busy1;
  logic        done1;
  logic [7:0]  s1;
  logic        cout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_suma_serial #(.W(4), .K(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .s(s), .cout(cout)
  );

  control_suma_serial #(.W(8), .K(1)) dut_k1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .s(s1), .cout(cout1)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    start1 = 1'b0; a1 = 8'h00; b1 = 8'h00; cin1 = 1'b0;
    @(negedge clk);
    step();
    step();
    total++;
    if ({ready, busy, done, cout} !== 4'b1000 || s !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: got rdy/bsy/dn/co=%b s=%h, want 1000 s=0000",
               {ready, busy, done, cout}, s);
    end
    total++;
    if ({ready1, busy1, done1, cout1} !== 4'b1000 || s1 !== 8'h00) begin
      bad++;
      $display("FAIL reset_state_k1: got %b s=%h, want 1000 s=00",
               {ready1, busy1, done1, cout1}, s1);
    end
    rst_n = 1'b1;
    step();
  endtask

  // One isolated op: done must appear exactly once, 4 edges after accept
  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] exp_s, input logic exp_c);
    int done_at;
    int pulses;
    logic [15:0] got_s;
    logic got_c;
    done_at = -1; pulses = 0; got_s = 16'h0000; got_c = 1'b0;
    a = av; b = bv; cin = cv; start = 1'b1;
    step();
    start = 1'b0; a = ~av; b = ~bv; cin = ~cv;
    total++;
    if ({ready, busy, done} !== 3'b010) begin
      bad++;
      $display("FAIL %s_busy: got rdy/bsy/dn=%b, want 010", name, {ready, busy, done});
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) begin
          done_at = i; got_s = s; got_c = cout;
        end
      end
    end
    total++;
    if (done_at != 4 || pulses != 1) begin
      bad++;
      $display("FAIL %s_latency: got done at +%0d (%0d pulses), want +4 (1 pulse)",
               name, done_at, pulses);
    end
    total++;
    if (got_s !== exp_s || got_c !== exp_c) begin
      bad++;
      $display("FAIL %s_result: got s=%h cout=%b, want s=%h cout=%b",
               name, got_s, got_c, exp_s, exp_c);
    end
    total++;
    if (s !== exp_s || cout !== exp_c || ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_hold: got s=%h cout=%b rdy=%b, want s=%h cout=%b rdy=1",
               name, s, cout, ready, exp_s, exp_c);
    end
  endtask

  task automatic test_chunk_carry();
    run_op("c2_ff_plus_1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    run_op("mix_cin", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    run_op("top_carry", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_ripple();
    run_op("c3_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
  endtask

  task automatic test_ignore_start();
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    step();
    step();
    step();
    total++;
    if (done !== 1'b1 || s !== 16'h2345 || cout !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start: got done=%b s=%h cout=%b, want done=1 s=2345 cout=0",
               done, s, cout);
    end
    start = 1'b0;
    step();
    step();
    total++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_idle: got rdy=%b bsy=%b, want rdy=1 bsy=0", ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || s !== 16'h0000 || cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%b bsy=%b s=%h cout=%b, want 1 0 0000 0",
               ready, busy, s, cout);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || s !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_nodone: got %0d pulses s=%h, want 0 pulses s=0000", pulses, s);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, pulses;
    logic [15:0] s_first, s_second;
    logic rdy_at6;
    d1 = -1; d2 = -1; pulses = 0; s_first = 16'h0000; s_second = 16'h0000; rdy_at6 = 1'b1;
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    step();
    a = 16'h00F0; b = 16'h000F;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 6) begin
        start = 1'b0; rdy_at6 = ready;
      end
      if (done === 1'b1) begin
        pulses++;
        if (d1 < 0) begin
          d1 = i; s_first = s;
        end else begin
          d2 = i; s_second = s;
        end
      end
    end
    total++;
    if (d1 != 4 || d2 != 10 || pulses != 2) begin
      bad++;
      $display("FAIL b2b_timing: got done at +%0d,+%0d (%0d pulses), want +4,+10 (2)",
               d1, d2, pulses);
    end
    total++;
    if (s_first !== 16'h0003 || s_second !== 16'h00FF) begin
      bad++;
      $display("FAIL b2b_results: got %h,%h, want 0003,00FF", s_first, s_second);
    end
    total++;
    if (rdy_at6 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_reaccept: got ready=%b after edge +6, want 0", rdy_at6);
    end
  endtask

  task automatic test_k1();
    a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    total++;
    if ({ready1, busy1, done1} !== 3'b010) begin
      bad++;
      $display("FAIL k1_busy: got rdy/bsy/dn=%b, want 010", {ready1, busy1, done1});
    end
    step();
    total++;
    if (done1 !== 1'b1 || s1 !== 8'h00 || cout1 !== 1'b1) begin
      bad++;
      $display("FAIL k1_result: got done=%b s=%h cout=%b, want 1 00 1", done1, s1, cout1);
    end
    step();
    total++;
    if (done1 !== 1'b0 || ready1 !== 1'b1 || cout1 !== 1'b1) begin
      bad++;
      $display("FAIL k1_after: got done=%b rdy=%b cout=%b, want 0 1 1", done1, ready1, cout1);
    end
  endtask

  initial begin
    test_reset();
    test_chunk_carry();
    test_ripple();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_k1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
